// File: rtl/mul_seq_pkg.sv
// Shared types and decode for the HI/LO multiply sequencer.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ACC
    } state_e;

    typedef enum logic [1:0] {
        OP_MULT,
        OP_MADD,
        OP_MSUB,
        OP_MUL
    } op_kind_e;

    // SPECIAL-class function codes (alu_op)
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    // SPECIAL2-class function codes (mul_op)
    localparam logic [5:0] FN_MADD  = 6'h00;
    localparam logic [5:0] FN_MADDU = 6'h01;
    localparam logic [5:0] FN_MUL   = 6'h02;
    localparam logic [5:0] FN_MSUB  = 6'h04;
    localparam logic [5:0] FN_MSUBU = 6'h05;

    typedef struct packed {
        logic     recog;
        logic     start;
        op_kind_e kind;
        logic     sgn;
        logic     mthi;
        logic     mtlo;
    } dec_t;

    function automatic dec_t decode_op(input logic alu_op, input logic mul_op,
                                       input logic [5:0] func);
        dec_t d;
        d = '0;
        if (alu_op) begin
            case (func)
                FN_MULT:          begin d.recog = 1'b1; d.start = 1'b1; d.kind = OP_MULT; d.sgn = 1'b1; end
                FN_MULTU:         begin d.recog = 1'b1; d.start = 1'b1; d.kind = OP_MULT; end
                FN_MFHI, FN_MFLO: d.recog = 1'b1;
                FN_MTHI:          begin d.recog = 1'b1; d.mthi = 1'b1; end
                FN_MTLO:          begin d.recog = 1'b1; d.mtlo = 1'b1; end
                default:          ;
            endcase
        end
        if (mul_op && !d.recog) begin
            case (func)
                FN_MADD:  begin d.recog = 1'b1; d.start = 1'b1; d.kind = OP_MADD; d.sgn = 1'b1; end
                FN_MADDU: begin d.recog = 1'b1; d.start = 1'b1; d.kind = OP_MADD; end
                FN_MUL:   begin d.recog = 1'b1; d.start = 1'b1; d.kind = OP_MUL;  d.sgn = 1'b1; end
                FN_MSUB:  begin d.recog = 1'b1; d.start = 1'b1; d.kind = OP_MSUB; d.sgn = 1'b1; end
                FN_MSUBU: begin d.recog = 1'b1; d.start = 1'b1; d.kind = OP_MSUB; end
                default:  ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/mul_pp32x8.sv
// Combinational 32x8 unsigned partial product.
module mul_pp32x8 (
    input  logic [31:0] a_i,
    input  logic [7:0]  b_i,
    output logic [39:0] p_o
);

    // one byte slice of the multiplier against the full multiplicand
    always_comb p_o = {8'd0, a_i} * {32'd0, b_i};

endmodule

// File: rtl/mul_sequencer.sv
// Four-cycle byte-serial multiplier feeding the HI/LO registers.
module mul_sequencer
    import mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        alu_op,
    input  logic        mul_op,
    input  logic [5:0]  func,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] mul_result,
    output logic        mul_valid
);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] a_q, b_q, hi_q, lo_q, mul_result_q;
    op_kind_e    kind_q;
    logic        neg_q, done_q, mul_valid_q;
    logic [63:0] acc_q;

    dec_t        dec;
    logic [31:0] rs_abs, rt_abs;
    logic [7:0]  b_slice;
    logic [39:0] pp;
    logic [63:0] acc_d, prod_d, hilo_d;

    // decode the presented op
    always_comb dec = decode_op(alu_op, mul_op, func);

    // magnitudes for signed ops, raw operands otherwise
    always_comb begin
        rs_abs = (dec.sgn && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        rt_abs = (dec.sgn && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    end

    // multiplier byte for the current CALC step, LSB first
    always_comb begin
        case (cnt_q)
            2'd0:    b_slice = b_q[7:0];
            2'd1:    b_slice = b_q[15:8];
            2'd2:    b_slice = b_q[23:16];
            default: b_slice = b_q[31:24];
        endcase
    end

    mul_pp32x8 u_pp (
        .a_i (a_q),
        .b_i (b_slice),
        .p_o (pp)
    );

    // accumulate the shifted partial product; sign fix-up applied to the final sum
    always_comb begin
        acc_d  = acc_q + ({24'd0, pp} << {cnt_q, 3'b000});
        prod_d = neg_q ? (64'd0 - acc_d) : acc_d;
    end

    // HI/LO update selected by op kind, acc_q holds the signed product in ACC
    always_comb begin
        hilo_d = {hi_q, lo_q};
        case (kind_q)
            OP_MULT: hilo_d = acc_q;
            OP_MADD: hilo_d = {hi_q, lo_q} + acc_q;
            OP_MSUB: hilo_d = {hi_q, lo_q} - acc_q;
            default: hilo_d = {hi_q, lo_q};
        endcase
    end

    // sequencer FSM with registered HI/LO, result and completion flags
    // (the signed product is formed on the CALC->ACC edge so done/mul_valid are
    // registered yet still high during the ACC cycle)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            kind_q       <= OP_MULT;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_result_q <= '0;
            done_q       <= 1'b0;
            mul_valid_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            mul_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_valid && !flush) begin
                        if (dec.start) begin
                            a_q     <= rs_abs;
                            b_q     <= rt_abs;
                            kind_q  <= dec.kind;
                            neg_q   <= dec.sgn & (rs_val[31] ^ rt_val[31]);
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_CALC;
                        end
                        if (dec.mthi) hi_q <= rs_val;
                        if (dec.mtlo) lo_q <= rs_val;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            acc_q       <= prod_d;
                            state_q     <= ST_ACC;
                            done_q      <= 1'b1;
                            mul_valid_q <= (kind_q == OP_MUL);
                            if (kind_q == OP_MUL) mul_result_q <= prod_d[31:0];
                        end else begin
                            acc_q <= acc_d;
                        end
                    end
                end
                ST_ACC: begin
                    state_q <= ST_IDLE;
                    if (!flush) {hi_q, lo_q} <= hilo_d;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign stall      = issue_valid & busy & dec.recog;
    assign done       = done_q & ~flush;
    assign mul_valid  = mul_valid_q & ~flush;
    assign mul_result = mul_result_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized self-checking bench for mul_sequencer against an arithmetic model.
module tb_mul_sequencer;

    localparam int K_NONE = -1;
    localparam int K_MULT = 0;
    localparam int K_MADD = 1;
    localparam int K_MSUB = 2;
    localparam int K_MUL  = 3;
    localparam int K_MTHI = 4;
    localparam int K_MTLO = 5;
    localparam int K_MF   = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        alu_op = 1'b0;
    logic        mul_op = 1'b0;
    logic [5:0]  func = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo, mul_result;
    logic        busy, stall, done, mul_valid;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [63:0] model_hl = '0;

    mul_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .alu_op      (alu_op),
        .mul_op      (mul_op),
        .func        (func),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .flush       (flush),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .mul_result  (mul_result),
        .mul_valid   (mul_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // op classification straight from the instruction table
    function automatic int classify(input logic a, input logic m, input logic [5:0] f,
                                    output logic sgn);
        sgn = 1'b0;
        if (a) begin
            case (f)
                6'h18: begin sgn = 1'b1; return K_MULT; end
                6'h19: return K_MULT;
                6'h10, 6'h12: return K_MF;
                6'h11: return K_MTHI;
                6'h13: return K_MTLO;
                default: ;
            endcase
        end
        if (m) begin
            case (f)
                6'h00: begin sgn = 1'b1; return K_MADD; end
                6'h01: return K_MADD;
                6'h02: begin sgn = 1'b1; return K_MUL; end
                6'h04: begin sgn = 1'b1; return K_MSUB; end
                6'h05: return K_MSUB;
                default: ;
            endcase
        end
        return K_NONE;
    endfunction

    // full 64-bit product modulo 2^64
    function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ae, be;
        ae = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        be = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ae * be;
    endfunction

    task automatic drive(input logic a, input logic m, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt);
        alu_op = a; mul_op = m; func = f; rs_val = rs; rt_val = rt; issue_valid = 1'b1;
    endtask

    // issue one op from IDLE; flush_at (1..5) raises flush in that busy cycle
    task automatic do_op(input logic a, input logic m, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt, input int flush_at);
        logic        sgn;
        int          k;
        logic [63:0] p, exp_hl;
        k = classify(a, m, f, sgn);
        p = ref_prod(sgn, rs, rt);
        drive(a, m, f, rs, rt);
        @(negedge clk);
        chk("stall_idle", stall, 1'b0);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        if (k inside {K_MULT, K_MADD, K_MSUB, K_MUL}) begin
            case (k)
                K_MULT:  exp_hl = p;
                K_MADD:  exp_hl = model_hl + p;
                K_MSUB:  exp_hl = model_hl - p;
                default: exp_hl = model_hl;
            endcase
            for (int i = 1; i <= 5; i++) begin
                if (i == flush_at) flush = 1'b1;
                @(negedge clk);
                chk("busy", busy, 1'b1);
                chk("done", done, (i == 5 && flush_at != 5));
                chk("mul_valid", mul_valid, (i == 5 && flush_at != 5 && k == K_MUL));
                if (i == 5 && flush_at != 5 && k == K_MUL)
                    chk("mul_result", mul_result, p[31:0]);
                @(posedge clk); #1;
                flush = 1'b0;
                if (i == flush_at) break;
            end
            if (flush_at == 0) model_hl = exp_hl;
        end else begin
            if (k == K_MTHI) model_hl[63:32] = rs;
            if (k == K_MTLO) model_hl[31:0]  = rs;
        end
        @(negedge clk);
        chk("busy_end", busy, 1'b0);
        chk("hi", hi, model_hl[63:32]);
        chk("lo", lo, model_hl[31:0]);
        @(posedge clk); #1;
    endtask

    // MULT followed by a held SPECIAL op: stall through CALC and ACC
    task automatic stall_test(input logic [5:0] held_fn);
        logic [31:0] rs, rt, held_rs;
        rs = $urandom; rt = $urandom; held_rs = $urandom;
        drive(1'b1, 1'b0, 6'h18, rs, rt);
        @(posedge clk); #1;
        func = held_fn; rs_val = held_rs;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("stall_busy", stall, 1'b1);
            @(posedge clk); #1;
        end
        model_hl = ref_prod(1'b1, rs, rt);
        @(negedge clk);
        chk("stall_release", stall, 1'b0);
        chk("lo_after_stall", lo, model_hl[31:0]);
        chk("hi_after_stall", hi, model_hl[63:32]);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        if (held_fn == 6'h13) model_hl[31:0] = held_rs;
        chk("lo_held_op", lo, model_hl[31:0]);
    endtask

    initial begin
        logic [5:0] alu_fns [6];
        logic [5:0] mul_fns [5];
        alu_fns = '{6'h18, 6'h19, 6'h10, 6'h11, 6'h12, 6'h13};
        mul_fns = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05};

        // reset state, with a multiply presented to show stall stays low
        drive(1'b1, 1'b0, 6'h18, 32'h1234, 32'h5678);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mul_result", mul_result, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mul_valid", mul_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue_valid = 1'b0;

        do_op(1'b1, 1'b0, 6'h18, 32'hFFFFFFFD, 32'd7, 0);
        chk("mult_neg3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        do_op(1'b1, 1'b0, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        do_op(1'b1, 1'b0, 6'h11, 32'd1, 32'd0, 0);
        do_op(1'b1, 1'b0, 6'h13, 32'd0, 32'd0, 0);
        do_op(1'b0, 1'b1, 6'h05, 32'd1, 32'd1, 0);
        chk("msubu_borrow", {hi, lo}, 64'h00000000_FFFFFFFF);
        do_op(1'b0, 1'b1, 6'h00, 32'hFFFFFFFF, 32'd1, 0);
        chk("madd_neg1", {hi, lo}, 64'h00000000_FFFFFFFE);

        stall_test(6'h12);
        stall_test(6'h13);

        do_op(1'b1, 1'b0, 6'h11, 32'd5, 32'd0, 0);
        do_op(1'b1, 1'b0, 6'h13, 32'd5, 32'd0, 0);
        do_op(1'b1, 1'b0, 6'h18, $urandom, $urandom, 2);
        chk("flush_hilo", {hi, lo}, 64'h00000005_00000005);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_no_done", done, 1'b0);
            @(posedge clk); #1;
        end

        // flush in IDLE wins over an issued op
        flush = 1'b1;
        drive(1'b1, 1'b0, 6'h11, 32'hDEAD_BEEF, 32'd0);
        @(posedge clk); #1;
        func = 6'h18;
        @(posedge clk); #1;
        issue_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", busy, 1'b0);
        chk("idle_flush_hi", hi, 32'd5);
        @(posedge clk); #1;

        do_op(1'b0, 1'b1, 6'h02, 32'h0001_0000, 32'h0001_0001, 0);
        chk("mul_word", mul_result, 32'h0001_0000);
        chk("mul_hilo_kept", {hi, lo}, 64'h00000005_00000005);

        repeat (60) begin
            int          sel, fa;
            logic        a, m;
            logic [5:0]  f;
            sel = $urandom_range(0, 9);
            a = (sel < 5);
            m = (sel >= 5 && sel < 9);
            if ($urandom_range(0, 3) == 0) f = 6'($urandom);
            else if (a) f = alu_fns[$urandom_range(0, 5)];
            else f = mul_fns[$urandom_range(0, 4)];
            fa = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 0;
            do_op(a, m, f, $urandom, $urandom, fa);
        end

        // asynchronous reset mid-CALC
        drive(1'b1, 1'b0, 6'h18, $urandom | 32'h1, $urandom | 32'h1);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_mul_result", mul_result, 32'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_mul_valid", mul_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_hl = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
